hilo_div_seq: RTL and testbench
===============================

HILO_DIV_SEQ -- requirements
Module: hilo_div_seq

Interface
REQ-001 The block SHALL have exactly one clock and one reset: clock port `clk`, reset port `rst`; reset is asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-low reset (0 = reset asserted).
REQ-004 start_i  input  1  request a division; level, held high by the execute stage until ready_o is seen.
REQ-005 annul_i  input  1  cancel the current division (pipeline flush).
REQ-006 signed_div_i  input  1  1 = signed (div), 0 = unsigned (divu).
REQ-007 opdata1_i  input  32  dividend.
REQ-008 opdata2_i  input  32  divisor.
REQ-009 result_o  output  64  {remainder[31:0] -> HI, quotient[31:0] -> LO}.
REQ-010 ready_o  output  1  result valid; also the inverse of the stall request toward the pipeline controller.
REQ-011 busy_o  output  1  1 while in states ON or BYZERO (execute-stage stall request).

Function
REQ-012 The block SHALL implement four states: IDLE, BYZERO, ON, END.
REQ-013 IDLE: if start_i=1, annul_i=0 and opdata2_i=0, go to BYZERO; if start_i=1, annul_i=0 and opdata2_i!=0, go to ON and latch both operands; otherwise stay in IDLE.
REQ-014 On entry to ON, the magnitude of each operand SHALL be latched (two's-complement negated if signed_div_i=1 and its bit 31 is 1), together with the sign flags and signed_div_i; the iteration counter SHALL be cleared to 0.
REQ-015 ON: one restoring-division step per clock: shift {partial remainder, dividend} left by 1 and trial-subtract the divisor from the 33-bit upper part; if the result is non-negative, keep it and shift in quotient bit 1, else shift in 0.
REQ-016 ON: after the 32nd step (counter 31 -> 32), go to END on the same edge.
REQ-017 On the edge entering END, result_o SHALL be loaded: the quotient is negated if signed and the operand signs differ; the remainder is negated if signed and the dividend was negative.
REQ-018 BYZERO: go to END on the next edge with result_o = 64'h0.
REQ-019 END: ready_o=1; stay in END while start_i=1; when start_i=0, go to IDLE with ready_o=0 and result_o=0 on that edge.
REQ-020 annul_i=1 in ON or BYZERO SHALL return the block to IDLE on the next edge, with ready_o=0; no result is produced.
REQ-021 annul_i=1 in END SHALL have no effect; exit from END depends only on start_i.
REQ-022 Operand changes while in ON SHALL be ignored (latched copies only).
REQ-023 Latency SHALL be fixed: ready_o is high 33 edges after the edge that samples start_i in IDLE (nonzero divisor), and 2 edges after it for a zero divisor; latency is independent of operand values.
REQ-024 Overflow case 0x80000000 / 0xFFFFFFFF (signed) SHALL give quotient 0x80000000 and remainder 0 (natural 32-bit truncation; no exception).
REQ-025 All outputs SHALL be registered; busy_o SHALL be decoded from the state register only.

Reset
REQ-026 While rst=0: state=IDLE, counter=0, result_o=64'h0, ready_o=0, busy_o=0, all latched operands and sign flags cleared.
REQ-027 Reset asserted mid-division SHALL abort immediately (asynchronously); after release the block SHALL be in IDLE and accept a new start_i on the first edge.

Structure
REQ-028 The following SHALL be added to the shared defines file: the state encodings (DivFree, DivByZero, DivOn, DivEnd, 2 bits), DivResultReady/DivResultNotReady, DivStart/DivStop, and the iteration count constant 32.
REQ-029 The block SHALL be a single module with no sub-modules; the trial subtract is one 33-bit subtractor inside it.

Verification
REQ-030 Unsigned 100/7, start held -> ready_o=1 exactly 33 edges after start is sampled; result_o={32'd2, 32'd14}; start_i dropped -> IDLE next edge, ready_o=0.
REQ-031 Signed -7/2 (0xFFFFFFF9 / 0x00000002) -> result_o={32'hFFFFFFFF, 32'hFFFFFFFD}; the same operands unsigned -> {32'h1, 32'h7FFFFFFC}.
REQ-032 Divisor 0 (12345 / 0) -> BYZERO for one cycle, ready_o=1 two edges after start, result_o=0; busy_o=1 for exactly one cycle.
REQ-033 Signed 0x80000000 / 0xFFFFFFFF -> result_o={32'h0, 32'h80000000}, latency 33 edges.
REQ-034 annul_i pulse at step 10 -> IDLE next edge, ready_o never asserts; a new 9/3 start then gives {0, 3} with full latency.
REQ-035 rst=0 at step 20 -> all outputs 0 immediately (no clock edge needed); after release, 0xFFFFFFFF/1 unsigned -> {0, 32'hFFFFFFFF}.

Source files
------------

// File: rtl/hilo_div_seq_pkg.sv
// Shared definitions for the HI/LO sequential divider: state encodings,
// handshake levels and the iteration count.
package hilo_div_seq_pkg;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    localparam int DIV_ITER = 32;

endpackage

// File: rtl/hilo_div_seq.sv
// 32-step restoring divider producing {remainder, quotient} for the HI/LO pair.
// Signed operands are divided as magnitudes and the signs are fixed up at the end.
module hilo_div_seq
    import hilo_div_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        annul_i,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    output logic [63:0] result_o,
    output logic        ready_o,
    output logic        busy_o
);

    div_state_e  state, state_nxt;
    logic [5:0]  cnt;
    logic [31:0] rem, dq, dvsr;
    logic        sdiv, sign1, sign2;

    logic [32:0] upper;
    logic [33:0] diff;
    logic        qbit;
    logic [31:0] rem_nxt, q_nxt, mag1, mag2, q_fin, r_fin;

    // One trial subtract per step; diff[33] is the borrow out.
    always_comb begin
        upper   = {rem, dq[31]};
        diff    = {1'b0, upper} - {2'b00, dvsr};
        qbit    = ~diff[33];
        rem_nxt = qbit ? diff[31:0] : upper[31:0];
        q_nxt   = {dq[30:0], qbit};
        q_fin   = (sdiv && (sign1 ^ sign2)) ? (~q_nxt + 32'd1) : q_nxt;
        r_fin   = (sdiv && sign1) ? (~rem_nxt + 32'd1) : rem_nxt;
        mag1    = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
        mag2    = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            DivFree: begin
                if (start_i == DivStart && !annul_i)
                    state_nxt = (opdata2_i == 32'd0) ? DivByZero : DivOn;
            end
            DivByZero: state_nxt = annul_i ? DivFree : DivEnd;
            DivOn: begin
                if (annul_i)
                    state_nxt = DivFree;
                else if (cnt == 6'(DIV_ITER - 1))
                    state_nxt = DivEnd;
            end
            DivEnd: begin
                if (start_i == DivStop)
                    state_nxt = DivFree;
            end
            default: state_nxt = DivFree;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= DivFree;
            cnt      <= '0;
            rem      <= '0;
            dq       <= '0;
            dvsr     <= '0;
            sdiv     <= 1'b0;
            sign1    <= 1'b0;
            sign2    <= 1'b0;
            result_o <= '0;
            ready_o  <= DivResultNotReady;
        end else begin
            state <= state_nxt;
            case (state)
                DivFree: begin
                    if (state_nxt == DivOn) begin
                        rem   <= '0;
                        dq    <= mag1;
                        dvsr  <= mag2;
                        sdiv  <= signed_div_i;
                        sign1 <= opdata1_i[31];
                        sign2 <= opdata2_i[31];
                        cnt   <= '0;
                    end
                end
                DivByZero: begin
                    if (!annul_i) begin
                        result_o <= '0;
                        ready_o  <= DivResultReady;
                    end
                end
                DivOn: begin
                    if (!annul_i) begin
                        rem <= rem_nxt;
                        dq  <= q_nxt;
                        cnt <= cnt + 6'd1;
                        // Last step loads the sign-corrected result on the same edge.
                        if (cnt == 6'(DIV_ITER - 1)) begin
                            result_o <= {r_fin, q_fin};
                            ready_o  <= DivResultReady;
                        end
                    end
                end
                DivEnd: begin
                    if (start_i == DivStop) begin
                        result_o <= '0;
                        ready_o  <= DivResultNotReady;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy_o = (state == DivOn) || (state == DivByZero);

endmodule

// File: tb/tb_hilo_div_seq.sv
// Self-checking bench for hilo_div_seq: spec vectors, randomized operands
// against an arithmetic model, and annul / reset corner sequences.
module tb_hilo_div_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_i = 1'b0;
    logic        annul_i = 1'b0;
    logic        signed_div_i = 1'b0;
    logic [31:0] opdata1_i = '0;
    logic [31:0] opdata2_i = '0;
    logic [63:0] result_o;
    logic        ready_o;
    logic        busy_o;

    int checks = 0;
    int errors = 0;

    hilo_div_seq dut (
        .clk(clk), .rst(rst), .start_i(start_i), .annul_i(annul_i),
        .signed_div_i(signed_div_i), .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
        .result_o(result_o), .ready_o(ready_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [63:0] exp;
        int          lat;
        string       nm;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'h0;
        sa = s ? longint'($signed(a)) : longint'({32'b0, a});
        sb = s ? longint'($signed(b)) : longint'({32'b0, b});
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Full transaction: start held until ready, operands scrambled once started,
    // annul pulsed in END (must be ignored), then start dropped.
    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [63:0] exp, input int exp_lat, input string nm);
        int lat, bz;
        lat = 0;
        bz  = 0;
        @(negedge clk);
        opdata1_i = a; opdata2_i = b; signed_div_i = s; start_i = 1'b1;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (busy_o) bz++;
            opdata1_i = $urandom; opdata2_i = $urandom; signed_div_i = 1'($urandom);
        end while (!ready_o && lat < 40);
        chk({nm, " ready"}, 64'(ready_o), 64'd1);
        chk({nm, " latency"}, 64'(lat), 64'(exp_lat));
        chk({nm, " busy cycles"}, 64'(bz), 64'(exp_lat - 1));
        chk({nm, " result"}, result_o, exp);
        annul_i = 1'b1;
        @(negedge clk);
        chk({nm, " END hold ready"}, 64'(ready_o), 64'd1);
        chk({nm, " END hold result"}, result_o, exp);
        annul_i = 1'b0;
        start_i = 1'b0;
        @(negedge clk);
        chk({nm, " exit ready"}, 64'(ready_o), 64'd0);
        chk({nm, " exit result"}, result_o, 64'h0);
        chk({nm, " exit busy"}, 64'(busy_o), 64'd0);
    endtask

    initial begin
        int seen;
        logic [31:0] ra, rb;
        logic rs;

        vecs[0] = '{32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 33, "u100/7"};
        vecs[1] = '{32'hFFFFFFF9, 32'd2, 1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33, "s-7/2"};
        vecs[2] = '{32'hFFFFFFF9, 32'd2, 1'b0, {32'h1, 32'h7FFFFFFC}, 33, "u-7/2"};
        vecs[3] = '{32'd12345, 32'd0, 1'b0, 64'h0, 2, "div0"};
        vecs[4] = '{32'h80000000, 32'hFFFFFFFF, 1'b1, {32'h0, 32'h80000000}, 33, "ovf"};
        vecs[5] = '{32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, 33, "u9/3"};
        vecs[6] = '{32'hFFFFFFFF, 32'd1, 1'b0, {32'd0, 32'hFFFFFFFF}, 33, "umax/1"};
        vecs[7] = '{32'd7, 32'hFFFFFFFE, 1'b1, {32'd1, 32'hFFFFFFFD}, 33, "s7/-2"};

        #1;
        chk("reset result", result_o, 64'h0);
        chk("reset ready", 64'(ready_o), 64'd0);
        chk("reset busy", 64'(busy_o), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) do_div(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].exp, vecs[i].lat, vecs[i].nm);

        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 15));
                2: rb = 32'hFFFFFFFF - 32'($urandom_range(0, 15));
                default: rb = $urandom;
            endcase
            rs = 1'($urandom);
            do_div(ra, rb, rs, ref_div(ra, rb, rs), (rb == 0) ? 2 : 33, $sformatf("rand%0d", i));
        end

        // Annul mid-division: back to IDLE, no result ever appears.
        @(negedge clk);
        opdata1_i = 32'd100; opdata2_i = 32'd7; signed_div_i = 1'b0; start_i = 1'b1;
        repeat (10) @(negedge clk);
        annul_i = 1'b1; start_i = 1'b0;
        @(negedge clk);
        annul_i = 1'b0;
        chk("annul busy", 64'(busy_o), 64'd0);
        chk("annul ready", 64'(ready_o), 64'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready_o || busy_o) seen++;
        end
        chk("annul no result", 64'(seen), 64'd0);
        do_div(32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, 33, "post-annul 9/3");

        // Annul while dividing by zero.
        @(negedge clk);
        opdata1_i = 32'd5; opdata2_i = 32'd0; start_i = 1'b1;
        @(negedge clk);
        chk("bz busy", 64'(busy_o), 64'd1);
        annul_i = 1'b1; start_i = 1'b0;
        @(negedge clk);
        annul_i = 1'b0;
        chk("bz annul ready", 64'(ready_o), 64'd0);
        chk("bz annul busy", 64'(busy_o), 64'd0);

        // Asynchronous reset mid-division.
        @(negedge clk);
        opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
        repeat (20) @(negedge clk);
        chk("pre-reset busy", 64'(busy_o), 64'd1);
        #2 rst = 1'b0; start_i = 1'b0;
        #1;
        chk("async reset busy", 64'(busy_o), 64'd0);
        chk("async reset ready", 64'(ready_o), 64'd0);
        chk("async reset result", result_o, 64'h0);
        @(negedge clk);
        rst = 1'b1;
        do_div(32'hFFFFFFFF, 32'd1, 1'b0, {32'd0, 32'hFFFFFFFF}, 33, "post-reset umax/1");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
